frog_game_ctrl: RTL
===================

# frog_game_ctrl

Game-flow controller for the two-player frog-crossing VGA game. It consumes the player position and the per-pixel collision flag produced by the display/obstacle stage. It owns the game state machine, the per-player scores and turn handover, and it issues respawn requests back to the player-movement logic. Its state and score outputs drive the LD and SSD stages directly.

## Interface
Parameters:
- WIN_SCORE, 10 — goals needed to win; compared with ==, must fit in 4 bits
- TURN_TICKS, 240 — turn time limit, counted in tick pulses (used only with GAME_TIMER_EN)
- TIMER_W, 8 — width of the turn timer; must satisfy TURN_TICKS < 2^TIMER_W

Ports:
- board_clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  single-cycle enable, one per player-movement period
- start  in  1  raw slide switch, asynchronous to board_clk
- collision  in  1  level, high while the scanned pixel overlaps player and obstacle
- player_y  in  15  one-hot player row; bit 14 = start row, bit 0 = goal row
- state  out  2  QI=00, QGAME_1=01, QGAME_2=10, QDONE=11
- p1_score  out  4  player 1 goals
- p2_score  out  4  player 2 goals
- respawn  out  1  one-cycle pulse; player logic reloads its start position
- winner  out  1  0 = player 1, 1 = player 2; valid in QDONE
- time_left  out  TIMER_W  remaining ticks in the current turn

## Operation
- Reset values: state=QI, p1_score=0, p2_score=0, respawn=0, winner=0, time_left=0, armed=0, sync flops=0.
- start passes through a 2-flop synchronizer. start_rise is the rising-edge detect of the synchronized value.
- armed flag:
  - Cleared on every accepted event.
  - Set on a cycle where player_y[14]=1 and collision=0.
  - Goal and collision events are accepted only when armed=1. This blocks repeat counting while collision stays high or while player_y still shows the goal row.
- goal_evt = armed & player_y[0]. coll_evt = armed & collision & ~player_y[0].
- If both conditions are true in the same cycle, the goal wins.
- QI:
  - On start_rise: go to QGAME_1, clear both scores, pulse respawn, load the timer.
- QGAME_1 / QGAME_2:
  - goal_evt: increment the active player's score and pulse respawn.
    - If the new score == WIN_SCORE: go to QDONE and set winner to the active player.
    - Otherwise: stay in the current state.
  - coll_evt: pulse respawn, swap to the other QGAME state, reload the timer.
  - start synchronized low: go to QI and keep the scores (abort).
- QDONE:
  - Scores frozen, no events accepted.
  - On start_rise: go to QI. The switch must be taken low then high, so a rise is needed.
- Score arithmetic is 4-bit. It never exceeds WIN_SCORE because of the QDONE transition, so no wrap occurs.
- Reset mid-game: asynchronous return to reset values, no respawn pulse.

## Timing
- All outputs are registered.
- An event sampled at clock edge N shows its effect on state, score and respawn after edge N. respawn is high for exactly the cycle following edge N.
- start-to-QGAME_1 latency: 3 board_clk cycles (2 synchronizer cycles + 1 for the edge register) plus 1 output register.
- Only the timer and time_left use tick. Events are evaluated every board_clk cycle.
- The collision input may pulse for only a few pixel clocks per frame. Any single high cycle while armed is a valid event.

## Configuration
- GAME_TIMER_EN defined:
  - time_left loads TURN_TICKS on every turn start and every respawn.
  - time_left decrements once per tick in the QGAME states.
  - On a tick where time_left==1, a timeout is treated exactly as coll_evt (respawn and turn swap), regardless of armed.
  - A timeout and a goal in the same cycle: the goal wins.
- GAME_TIMER_EN undefined: no timer logic; time_left is tied to 0; no timeouts occur.

## Structure
- Package frog_game_pkg holds:
  - the state encodings QI, QGAME_1, QGAME_2, QDONE
  - the start-row and goal-row bit indices (14, 0)
  - the WIN_SCORE default
- One sub-module, sync_edge: 2-flop synchronizer with a rising-edge pulse output. It is used for start.

## Test plan
- Reset, then start 0→1 → state goes to QGAME_1 within 4 cycles, scores 0/0, one respawn pulse.
- In QGAME_1, player_y=bit0 held 50 cycles with armed → p1_score=1 (increments once), one respawn. After player_y=bit14 it re-arms.
- In QGAME_1, collision pulses 3 times in one lockout window → exactly one swap to QGAME_2, one respawn, scores unchanged.
- p2_score=9, goal in QGAME_2 → p2_score=10, state=QDONE, winner=1. A further goal is ignored. start 0→1 → QI.
- Goal and collision asserted in the same cycle → score increments, state stays, no swap.
- GAME_TIMER_EN with TURN_TICKS=5, no events → after 5 ticks respawn fires and the turn swaps to QGAME_2, time_left reloads to 5. Assert reset mid-count → all outputs return to their reset values.

Source files
------------

// File: rtl/frog_game_pkg.sv
// Shared types and constants for the frog-crossing game-flow controller.
package frog_game_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_e;

    localparam int ROW_W         = 15;
    localparam int ROW_START     = 14;
    localparam int ROW_GOAL      = 0;
    localparam int WIN_SCORE_DEF = 10;

    function automatic game_state_e other_player(input game_state_e s);
        return (s == QGAME_1) ? QGAME_2 : QGAME_1;
    endfunction

endpackage

// File: rtl/frog_game_if.sv
// Bundle between the player/obstacle stages and the game-flow controller.
interface frog_game_if
    import frog_game_pkg::*;
#(
    parameter int TIMER_W = 8
);
    logic               tick;
    logic               start;
    logic               collision;
    logic [ROW_W-1:0]   player_y;
    logic [1:0]         state;
    logic [3:0]         p1_score;
    logic [3:0]         p2_score;
    logic               respawn;
    logic               winner;
    logic [TIMER_W-1:0] time_left;

    modport master (
        output tick, start, collision, player_y,
        input  state, p1_score, p2_score, respawn, winner, time_left
    );

    modport slave (
        input  tick, start, collision, player_y,
        output state, p1_score, p2_score, respawn, winner, time_left
    );
endinterface

// File: rtl/frog_game_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse.
module sync_edge (
    input  logic board_clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign sync = sync_q;
    assign rise = rise_q;
endmodule

// File: rtl/frog_game_ctrl.sv
// Game-flow controller: game FSM, scores, turn handover and respawn requests.
// Optional turn timer enabled by defining GAME_TIMER_EN.
//
// state   | meaning
// QI      | idle, waiting for a start switch rise
// QGAME_1 | player 1 turn
// QGAME_2 | player 2 turn
// QDONE   | a player reached WIN_SCORE, scores frozen
module frog_game_ctrl
    import frog_game_pkg::*;
#(
    parameter int WIN_SCORE  = WIN_SCORE_DEF,
    parameter int TURN_TICKS = 240,
    parameter int TIMER_W    = 8
) (
    input  logic       board_clk,
    input  logic       reset,
    frog_game_if.slave bus
);
    localparam logic [3:0] WIN_4 = 4'(WIN_SCORE);

    game_state_e state_q, state_d;
    logic [3:0]  p1_q, p1_d;
    logic [3:0]  p2_q, p2_d;
    logic        respawn_q, respawn_d;
    logic        winner_q, winner_d;
    logic        armed_q, armed_d;

    logic        start_sync, start_rise;
    logic        in_game, goal_evt, coll_evt, timeout, swap;
    logic [3:0]  score_inc;
    logic        unused_in;

    sync_edge u_start_sync (
        .board_clk (board_clk),
        .reset     (reset),
        .din       (bus.start),
        .sync      (start_sync),
        .rise      (start_rise)
    );

    assign in_game   = (state_q == QGAME_1) || (state_q == QGAME_2);
    assign goal_evt  = in_game & armed_q & bus.player_y[ROW_GOAL];
    assign coll_evt  = in_game & armed_q & bus.collision & ~bus.player_y[ROW_GOAL];
    // Goal has priority over both a collision and a timeout in the same cycle.
    assign swap      = ~goal_evt & (coll_evt | timeout);
    assign score_inc = ((state_q == QGAME_2) ? p2_q : p1_q) + 4'd1;

    always_comb begin
        state_d   = state_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        respawn_d = 1'b0;
        winner_d  = winner_q;
        armed_d   = armed_q;

        if (bus.player_y[ROW_START] && !bus.collision) armed_d = 1'b1;

        unique case (state_q)
            QI: begin
                if (start_rise) begin
                    state_d   = QGAME_1;
                    p1_d      = 4'd0;
                    p2_d      = 4'd0;
                    winner_d  = 1'b0;
                    respawn_d = 1'b1;
                end
            end
            QGAME_1, QGAME_2: begin
                if (goal_evt) begin
                    respawn_d = 1'b1;
                    if (state_q == QGAME_1) p1_d = score_inc;
                    else                    p2_d = score_inc;
                    if (score_inc == WIN_4) begin
                        state_d  = QDONE;
                        winner_d = (state_q == QGAME_2);
                    end
                end else if (swap) begin
                    respawn_d = 1'b1;
                    state_d   = other_player(state_q);
                end else if (!start_sync) begin
                    state_d = QI;
                end
            end
            QDONE: begin
                if (start_rise) state_d = QI;
            end
            default: state_d = QI;
        endcase

        // Every respawn puts the frog back on the start row; re-arm from there.
        if (respawn_d) armed_d = 1'b0;
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q   <= QI;
            p1_q      <= 4'd0;
            p2_q      <= 4'd0;
            respawn_q <= 1'b0;
            winner_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            respawn_q <= respawn_d;
            winner_q  <= winner_d;
            armed_q   <= armed_d;
        end
    end

`ifdef GAME_TIMER_EN
    localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_TICKS);

    logic [TIMER_W-1:0] time_left_q, time_left_d;

    assign timeout = in_game & bus.tick & (time_left_q == TIMER_W'(1));

    always_comb begin
        time_left_d = time_left_q;
        if (respawn_d)
            time_left_d = TURN_LOAD;
        else if (in_game && bus.tick && (time_left_q != '0))
            time_left_d = time_left_q - TIMER_W'(1);
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) time_left_q <= '0;
        else       time_left_q <= time_left_d;
    end

    assign bus.time_left = time_left_q;
    assign unused_in     = ^bus.player_y[ROW_START-1:ROW_GOAL+1];
`else
    assign timeout       = 1'b0;
    assign bus.time_left = '0;
    assign unused_in     = ^{bus.player_y[ROW_START-1:ROW_GOAL+1], bus.tick,
                             TIMER_W'(TURN_TICKS)};
`endif

    assign bus.state    = state_q;
    assign bus.p1_score = p1_q;
    assign bus.p2_score = p2_q;
    assign bus.respawn  = respawn_q;
    assign bus.winner   = winner_q;
endmodule
